// File: rtl/flt_pkg.sv
`default_nettype none
// flt_pkg: constants and FSM state type shared by the float encode/decode paths.
// Rev 1.0
package flt_pkg;
  localparam int FLT_BIAS           = 127;
  localparam int FLT_EXP_W          = 8;
  localparam int FLT_FRAC_W         = 23;
  localparam int FLT_FRAC_BITS_DEF  = 12;
  localparam int FLT_EXP_OFS        = FLT_BIAS - FLT_FRAC_BITS_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } flt_state_e;
endpackage
`default_nettype wire

// File: rtl/flt_encode_seq_if.sv
`default_nettype none
// flt_encode_seq_if: input/output valid-ready channels of the fixed-to-float encoder.
// Rev 1.0
interface flt_encode_seq_if #(
  parameter int INT_W = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [INT_W-1:0] int_val;
  logic             pos;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      flt_value;
  logic             busy;

  modport master (
    output in_valid, int_val, pos, out_ready,
    input  in_ready, out_valid, flt_value, busy
  );

  modport slave (
    input  in_valid, int_val, pos, out_ready,
    output in_ready, out_valid, flt_value, busy
  );
endinterface
`default_nettype wire

// File: rtl/flt_round_pack.sv
`default_nettype none
// flt_round_pack: RNE rounding of a normalised magnitude and IEEE-754 single packing.
// Rev 1.0
module flt_round_pack
  import flt_pkg::*;
#(
  parameter int INT_W     = 128,
  parameter int FRAC_BITS = FLT_FRAC_BITS_DEF
) (
  input  wire logic [INT_W-2:0]         i_mag_frac,
  input  wire logic [$clog2(INT_W)-1:0] i_cnt,
  input  wire logic                     i_sgn,
  input  wire logic                     i_zero,
  output logic      [31:0]              o_flt
);
  localparam int CNT_W   = $clog2(INT_W);
  localparam int EXP_TOP = FLT_EXP_OFS + (FLT_FRAC_BITS_DEF - FRAC_BITS) + INT_W - 1;
  localparam logic [FLT_EXP_W-1:0] C_EXP_TOP = FLT_EXP_W'(EXP_TOP);

  // Hidden bit is dropped by the caller; bit INT_W-2 is the first stored fraction bit.
  logic [FLT_FRAC_W-1:0] w_frac;
  logic                  w_g;
  logic                  w_s;
  logic                  w_rnd_up;
  logic [FLT_FRAC_W:0]   w_frac_sum;
  logic [FLT_EXP_W-1:0]  w_exp;

  assign w_frac     = i_mag_frac[INT_W-2 -: FLT_FRAC_W];
  assign w_g        = i_mag_frac[INT_W-2-FLT_FRAC_W];
  assign w_s        = |i_mag_frac[INT_W-3-FLT_FRAC_W:0];
  assign w_rnd_up   = w_g & (w_s | w_frac[0]);
  assign w_frac_sum = {1'b0, w_frac} + {{FLT_FRAC_W{1'b0}}, w_rnd_up};
  assign w_exp      = C_EXP_TOP
                    - {{(FLT_EXP_W-CNT_W){1'b0}}, i_cnt}
                    + {{(FLT_EXP_W-1){1'b0}}, w_frac_sum[FLT_FRAC_W]};

  assign o_flt = i_zero ? {i_sgn, 31'b0}
                        : {i_sgn, w_exp, w_frac_sum[FLT_FRAC_W-1:0]};
endmodule
`default_nettype wire

// File: rtl/flt_encode_seq.sv
`default_nettype none
// flt_encode_seq: sequential Q116.12 magnitude + sign to IEEE-754 single converter.
// Rev 1.0
module flt_encode_seq
  import flt_pkg::*;
#(
  parameter int INT_W     = 128,
  parameter int FRAC_BITS = 12,
  parameter int COARSE    = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  flt_encode_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(INT_W);

  flt_state_e       r_state,     w_state_nxt;
  logic [INT_W-1:0] r_mag,       w_mag_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  logic             r_sgn,       w_sgn_nxt;
  logic             r_zero,      w_zero_nxt;
  logic [31:0]      r_flt,       w_flt_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [31:0]      w_packed;

  flt_round_pack #(
    .INT_W     (INT_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_pack (
    .i_mag_frac (r_mag[INT_W-2:0]),
    .i_cnt      (r_cnt),
    .i_sgn      (r_sgn),
    .i_zero     (r_zero),
    .o_flt      (w_packed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mag       <= '0;
      r_cnt       <= '0;
      r_sgn       <= 1'b0;
      r_zero      <= 1'b0;
      r_flt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mag       <= w_mag_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sgn       <= w_sgn_nxt;
      r_zero      <= w_zero_nxt;
      r_flt       <= w_flt_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mag_nxt       = r_mag;
    w_cnt_nxt       = r_cnt;
    w_sgn_nxt       = r_sgn;
    w_zero_nxt      = r_zero;
    w_flt_nxt       = r_flt;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_mag_nxt   = bus.int_val;
          w_sgn_nxt   = ~bus.pos;
          w_cnt_nxt   = '0;
          w_zero_nxt  = 1'b0;
          w_state_nxt = NORM;
        end
      end
      NORM: begin
        // Coarse steps skip empty top bytes before single-bit steps finish the job.
        if (r_mag == '0) begin
          w_zero_nxt  = 1'b1;
          w_state_nxt = ROUND;
        end else if (r_mag[INT_W-1]) begin
          w_state_nxt = ROUND;
        end else if (r_mag[INT_W-1 -: COARSE] == '0) begin
          w_mag_nxt = r_mag << COARSE;
          w_cnt_nxt = r_cnt + CNT_W'(COARSE);
        end else begin
          w_mag_nxt = r_mag << 1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ROUND: begin
        w_flt_nxt       = w_packed;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state == NORM) || (r_state == ROUND);
  assign bus.out_valid = r_out_valid;
  assign bus.flt_value = r_flt;
endmodule
`default_nettype wire
